// File: rtl/hilo_md_sched_if.sv
// E-stage HI/LO sequencing bus: operation request, pipeline hints and
// the controller's latched operands, strobes and stall.
interface hilo_md_sched_if;
  logic        in_opValid;
  logic [2:0]  in_op;
  logic [31:0] in_num1;
  logic [31:0] in_num2;
  logic        in_dUsesHilo;
  logic        in_flush;
  logic        out_start;
  logic [2:0]  out_op;
  logic [31:0] out_num1;
  logic [31:0] out_num2;
  logic        out_busy;
  logic        out_commit;
  logic        out_hiWe;
  logic        out_loWe;
  logic        out_stallD;
  logic        out_protoErr;

  modport master (
    output in_opValid, in_op, in_num1, in_num2, in_dUsesHilo, in_flush,
    input  out_start, out_op, out_num1, out_num2, out_busy, out_commit,
           out_hiWe, out_loWe, out_stallD, out_protoErr
  );

  modport slave (
    input  in_opValid, in_op, in_num1, in_num2, in_dUsesHilo, in_flush,
    output out_start, out_op, out_num1, out_num2, out_busy, out_commit,
           out_hiWe, out_loWe, out_stallD, out_protoErr
  );
endinterface

// File: rtl/hilo_md_sched.sv
// HI/LO multiply/divide sequencer: latches one md op, counts its fixed
// latency, strobes commit, and stalls D-stage users of HI/LO meanwhile.
module hilo_md_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CW       = 4
) (
  input  logic           clk,
  input  logic           reset,
  hilo_md_sched_if.slave md
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_op, w_op_nx;
  logic [31:0]   r_num1, w_num1_nx;
  logic [31:0]   r_num2, w_num2_nx;
  logic          r_start, w_start_nx;
  logic          r_protoErr, w_protoErr_nx;

  logic w_idle, w_run, w_isMd, w_isAny, w_accept, w_commit;

  assign w_idle   = (r_state == IDLE);
  assign w_run    = (r_state == RUN);
  assign w_isMd   = md.in_opValid && (md.in_op >= 3'd1) && (md.in_op <= 3'd4);
  assign w_isAny  = md.in_opValid && (md.in_op >= 3'd1) && (md.in_op <= 3'd6);
  assign w_accept = w_idle && w_isMd && !md.in_flush;
  assign w_commit = w_run && (r_cnt == '0) && !md.in_flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_num1     <= '0;
      r_num2     <= '0;
      r_start    <= 1'b0;
      r_protoErr <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_op       <= w_op_nx;
      r_num1     <= w_num1_nx;
      r_num2     <= w_num2_nx;
      r_start    <= w_start_nx;
      r_protoErr <= w_protoErr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_op_nx       = r_op;
    w_num1_nx     = r_num1;
    w_num2_nx     = r_num2;
    w_start_nx    = 1'b0;
    w_protoErr_nx = r_protoErr;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = RUN;
          w_op_nx    = md.in_op;
          w_num1_nx  = md.in_num1;
          w_num2_nx  = md.in_num2;
          w_cnt_nx   = (md.in_op >= 3'd3) ? DIV_CNT : MULT_CNT;
          w_start_nx = 1'b1;
        end
      end
      RUN: begin
        // Flush outranks both the protocol check and normal completion.
        if (md.in_flush) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          if (w_isAny) w_protoErr_nx = 1'b1;
          if (r_cnt == '0) w_state_nx = IDLE;
          else             w_cnt_nx   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, including combinational strobes.
  assign md.out_start    = reset & r_start;
  assign md.out_op       = reset ? r_op   : '0;
  assign md.out_num1     = reset ? r_num1 : '0;
  assign md.out_num2     = reset ? r_num2 : '0;
  assign md.out_busy     = reset & w_run;
  assign md.out_commit   = reset & w_commit;
  assign md.out_hiWe     = reset & w_idle & md.in_opValid & (md.in_op == 3'd5) & !md.in_flush;
  assign md.out_loWe     = reset & w_idle & md.in_opValid & (md.in_op == 3'd6) & !md.in_flush;
  assign md.out_stallD   = reset & md.in_dUsesHilo & (w_run | (w_idle & w_isMd));
  assign md.out_protoErr = reset & r_protoErr;

endmodule

// File: tb/tb_hilo_md_sched.sv
// Directed bench for hilo_md_sched: reset, mult/div latency, stall,
// flush, mthi/mtlo strobes, protocol error and reset mid-operation.
module tb_hilo_md_sched;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks = 0;
  int unsigned errors = 0;

  hilo_md_sched_if md_if ();

  hilo_md_sched #(.MULT_LAT(5), .DIV_LAT(10), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, apply this cycle's inputs, then settle before checks.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] n1,
                      input logic [31:0] n2, input logic du, input logic fl);
    @(posedge clk);
    #1;
    md_if.in_opValid   = v;
    md_if.in_op        = op;
    md_if.in_num1      = n1;
    md_if.in_num2      = n2;
    md_if.in_dUsesHilo = du;
    md_if.in_flush     = fl;
    #1;
  endtask

  task automatic idle(input logic du);
    step(1'b0, 3'd0, 32'd0, 32'd0, du, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".start"},    md_if.out_start,    0);
    chk({tag, ".op"},       md_if.out_op,       0);
    chk({tag, ".num1"},     md_if.out_num1,     0);
    chk({tag, ".num2"},     md_if.out_num2,     0);
    chk({tag, ".busy"},     md_if.out_busy,     0);
    chk({tag, ".commit"},   md_if.out_commit,   0);
    chk({tag, ".hiWe"},     md_if.out_hiWe,     0);
    chk({tag, ".loWe"},     md_if.out_loWe,     0);
    chk({tag, ".stallD"},   md_if.out_stallD,   0);
    chk({tag, ".protoErr"}, md_if.out_protoErr, 0);
  endtask

  initial begin
    reset = 1'b0;
    md_if.in_opValid = 0; md_if.in_op = 0; md_if.in_num1 = 0;
    md_if.in_num2 = 0; md_if.in_dUsesHilo = 0; md_if.in_flush = 0;

    // 1. Reset held two cycles with a live request: everything reads 0.
    step(1'b1, 3'd1, 32'h55, 32'h66, 1'b1, 1'b0);
    chk_zero("rst0");
    step(1'b1, 3'd5, 32'h55, 32'h66, 1'b1, 1'b0);
    chk_zero("rst1");
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1'b0);
    #0;
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      chk("idle.busy", md_if.out_busy, 0);
      chk("idle.stall", md_if.out_stallD, 0);
      chk("idle.start", md_if.out_start, 0);
    end

    // 2. mult -3 * 7: start at T+1, busy T+1..T+5, commit only at T+5.
    step(1'b1, 3'd1, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    chk("mult.T.busy", md_if.out_busy, 0);
    chk("mult.T.start", md_if.out_start, 0);
    for (int k = 1; k <= 6; k++) begin
      idle(1'b0);
      chk($sformatf("mult.%0d.start", k),  md_if.out_start,  (k == 1));
      chk($sformatf("mult.%0d.busy", k),   md_if.out_busy,   (k <= 5));
      chk($sformatf("mult.%0d.commit", k), md_if.out_commit, (k == 5));
      if (k == 1) begin
        chk("mult.num1", md_if.out_num1, 32'hFFFFFFFD);
        chk("mult.num2", md_if.out_num2, 32'd7);
        chk("mult.op",   md_if.out_op,   3'd1);
      end
    end

    // 3. divu 100/7 with a HI/LO user in D: stall T..T+10, commit at T+10.
    step(1'b1, 3'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    chk("divu.T.stall", md_if.out_stallD, 1);
    for (int k = 1; k <= 11; k++) begin
      idle(1'b1);
      chk($sformatf("divu.%0d.stall", k),  md_if.out_stallD, (k <= 10));
      chk($sformatf("divu.%0d.commit", k), md_if.out_commit, (k == 10));
      if (k == 1) chk("divu.num1", md_if.out_num1, 32'd100);
    end

    // 4. div flushed at T+4; mult at T+5 is accepted and commits at T+10.
    step(1'b1, 3'd3, 32'd9, 32'd3, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      idle(1'b0);
      chk($sformatf("flush.%0d.busy", k), md_if.out_busy, 1);
    end
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush.4.busy", md_if.out_busy, 1);
    chk("flush.4.commit", md_if.out_commit, 0);
    step(1'b1, 3'd1, 32'd2, 32'd4, 1'b0, 1'b0);
    chk("flush.5.busy", md_if.out_busy, 0);
    chk("flush.5.commit", md_if.out_commit, 0);
    for (int k = 6; k <= 11; k++) begin
      idle(1'b0);
      chk($sformatf("flush.%0d.start", k),  md_if.out_start,  (k == 6));
      chk($sformatf("flush.%0d.busy", k),   md_if.out_busy,   (k <= 10));
      chk($sformatf("flush.%0d.commit", k), md_if.out_commit, (k == 10));
      if (k == 10) chk("flush.op", md_if.out_op, 3'd1);
    end
    chk("flush.protoErr", md_if.out_protoErr, 0);

    // 5. mthi in IDLE strobes hiWe; flushed mthi does not; mtlo while busy is an error.
    step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    chk("mthi.hiWe", md_if.out_hiWe, 1);
    chk("mthi.loWe", md_if.out_loWe, 0);
    chk("mthi.busy", md_if.out_busy, 0);
    step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b1);
    chk("mthi.flush.hiWe", md_if.out_hiWe, 0);
    step(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rsvd.busy", md_if.out_busy, 0);
    step(1'b1, 3'd1, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("rsvd.protoErr", md_if.out_protoErr, 0);
    step(1'b1, 3'd6, 32'h77, 32'd0, 1'b0, 1'b0);
    chk("mtlo.busy.loWe", md_if.out_loWe, 0);
    chk("mtlo.busy.protoErr", md_if.out_protoErr, 0);
    for (int k = 2; k <= 6; k++) begin
      idle(1'b0);
      chk($sformatf("mtlo.%0d.protoErr", k), md_if.out_protoErr, 1);
      chk($sformatf("mtlo.%0d.commit", k),   md_if.out_commit,   (k == 5));
    end

    // 6. mult, then multu back-to-back at T+6; reset at T+8 kills the second op.
    step(1'b1, 3'd1, 32'd3, 32'd5, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      idle(1'b0);
      chk($sformatf("b2b.%0d.commit", k), md_if.out_commit, (k == 5));
    end
    step(1'b1, 3'd2, 32'd8, 32'd9, 1'b0, 1'b0);
    chk("b2b.6.busy", md_if.out_busy, 0);
    idle(1'b0);
    chk("b2b.7.start", md_if.out_start, 1);
    chk("b2b.7.op", md_if.out_op, 3'd2);
    chk("b2b.7.num2", md_if.out_num2, 32'd9);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_zero("b2b.8");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("b2b.9.busy", md_if.out_busy, 0);
    chk("b2b.9.protoErr", md_if.out_protoErr, 0);
    for (int k = 10; k <= 13; k++) begin
      idle(1'b0);
      chk($sformatf("b2b.%0d.commit", k), md_if.out_commit, 0);
      chk($sformatf("b2b.%0d.busy", k),   md_if.out_busy,   0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $fatal(1, "FAIL timeout: simulation exceeded time limit");
  end

endmodule
